// File: rtl/aes_pkg.sv
// ============================================================================
// Module      : aes_pkg
// Description : Shared S-AES definitions: datapath width, GF(2^4) modulus,
//               nibble field slices, MixColumns FSM state type, and the
//               GF(2^4) multiply and ShiftRow helper functions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_pkg;

    localparam int          DATA_W  = 16;
    localparam logic [4:0]  GF_POLY = 5'h13;   // x^4 + x + 1

    // Nibble / column field slices of the 16-bit state.
    // s00=[15:12], s10=[11:8], s01=[7:4], s11=[3:0]
    localparam int NIB_W   = 4;
    localparam int COL_W   = 8;
    localparam int S00_HI  = 15;
    localparam int S00_LO  = 12;
    localparam int S10_HI  = 11;
    localparam int S10_LO  = 8;
    localparam int S01_HI  = 7;
    localparam int S01_LO  = 4;
    localparam int S11_HI  = 3;
    localparam int S11_LO  = 0;
    localparam int COL0_HI = 15;
    localparam int COL0_LO = 8;
    localparam int COL1_HI = 7;
    localparam int COL1_LO = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COL0 = 2'd1,
        COL1 = 2'd2,
        HOLD = 2'd3
    } mc_state_t;

    // GF(2^4) shift-and-add multiply; the running multiplicand is reduced
    // by the modulus whenever its bit 4 sets, so every product is 4 bits.
    function automatic logic [3:0] gf4_mul(input logic [3:0] a,
                                           input logic [3:0] b);
        logic [4:0] acc_a;
        logic [3:0] prod;
        acc_a = {1'b0, a};
        prod  = 4'h0;
        for (int i = 0; i < NIB_W; i++) begin
            if (b[i]) begin
                prod = prod ^ acc_a[3:0];
            end
            acc_a = {acc_a[3:0], 1'b0};
            if (acc_a[4]) begin
                acc_a = acc_a ^ GF_POLY;
            end
        end
        return prod;
    endfunction

    // ShiftRow for the upstream stage: swaps the two bottom-row nibbles.
    function automatic logic [DATA_W-1:0] shift_row(input logic [DATA_W-1:0] s);
        return {s[S00_HI:S00_LO], s[S11_HI:S11_LO],
                s[S01_HI:S01_LO], s[S10_HI:S10_LO]};
    endfunction

endpackage : aes_pkg

`default_nettype wire

// File: rtl/mix_column_pair.sv
// ============================================================================
// Module      : mix_column_pair
// Description : Combinational mixer for one 8-bit S-AES column (a, b).
//               Forward matrix [[1,4],[4,1]], inverse matrix [[9,2],[2,9]].
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mix_column_pair
    import aes_pkg::*;
(
    input  logic [COL_W-1:0] i_col,
    input  logic             i_inv,
    output logic [COL_W-1:0] o_col
);

    logic [NIB_W-1:0] w_a;
    logic [NIB_W-1:0] w_b;

    assign w_a = i_col[COL_W-1:NIB_W];
    assign w_b = i_col[NIB_W-1:0];

    // Matrix-vector product over GF(2^4) for the selected direction
    always_comb begin
        o_col = '0;
        if (i_inv) begin
            o_col = {gf4_mul(4'h9, w_a) ^ gf4_mul(4'h2, w_b),
                     gf4_mul(4'h2, w_a) ^ gf4_mul(4'h9, w_b)};
        end else begin
            o_col = {w_a ^ gf4_mul(4'h4, w_b),
                     gf4_mul(4'h4, w_a) ^ w_b};
        end
    end

endmodule : mix_column_pair

`default_nettype wire

// File: rtl/mix_columns_seq.sv
// ============================================================================
// Module      : mix_columns_seq
// Description : Sequential S-AES MixColumns / InvMixColumns stage. Captures
//               one 16-bit state per handshake, mixes one column per cycle
//               through a shared column mixer, then holds the result on a
//               valid/ready output. in_ready depends combinationally on
//               out_ready so a HOLD->COL0 back-to-back transfer is possible.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mix_columns_seq
    import aes_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_inv,
    input  logic              in_skip,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    mc_state_t         r_state_q;
    mc_state_t         w_state_d;
    logic [DATA_W-1:0] r_data_q;
    logic [DATA_W-1:0] w_data_d;
    logic              r_inv_q;
    logic              w_inv_d;
    logic              r_skip_q;
    logic              w_skip_d;
    logic              r_out_valid_q;
    logic              w_out_valid_d;

    logic [COL_W-1:0]  w_col_in;
    logic [COL_W-1:0]  w_col_out;
    logic              w_in_fire;

    // Accept when idle, or when the held result leaves in this same cycle
    assign in_ready  = (r_state_q == IDLE) ||
                       ((r_state_q == HOLD) && out_ready);
    assign w_in_fire = in_valid && in_ready;

    assign out_valid = r_out_valid_q;
    assign out_data  = r_data_q;

    // Single shared mixer; COL1 selects the low column, otherwise the high one
    assign w_col_in = (r_state_q == COL1) ? r_data_q[COL1_HI:COL1_LO]
                                          : r_data_q[COL0_HI:COL0_LO];

    mix_column_pair u_mix (
        .i_col (w_col_in),
        .i_inv (r_inv_q),
        .o_col (w_col_out)
    );

    // Next-state, capture and column write-back logic
    always_comb begin
        w_state_d = r_state_q;
        w_data_d  = r_data_q;
        w_inv_d   = r_inv_q;
        w_skip_d  = r_skip_q;
        case (r_state_q)
            IDLE: begin
                if (w_in_fire) begin
                    w_data_d  = in_data;
                    w_inv_d   = in_inv;
                    w_skip_d  = in_skip;
                    w_state_d = COL0;
                end
            end
            COL0: begin
                if (!r_skip_q) begin
                    w_data_d[COL0_HI:COL0_LO] = w_col_out;
                end
                w_state_d = COL1;
            end
            COL1: begin
                if (!r_skip_q) begin
                    w_data_d[COL1_HI:COL1_LO] = w_col_out;
                end
                w_state_d = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    if (w_in_fire) begin
                        w_data_d  = in_data;
                        w_inv_d   = in_inv;
                        w_skip_d  = in_skip;
                        w_state_d = COL0;
                    end else begin
                        w_state_d = IDLE;
                    end
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
        w_out_valid_d = (w_state_d == HOLD);
    end

    // State and datapath registers; reset discards any in-flight block
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= IDLE;
            r_data_q      <= '0;
            r_inv_q       <= 1'b0;
            r_skip_q      <= 1'b0;
            r_out_valid_q <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_data_q      <= w_data_d;
            r_inv_q       <= w_inv_d;
            r_skip_q      <= w_skip_d;
            r_out_valid_q <= w_out_valid_d;
        end
    end

endmodule : mix_columns_seq

`default_nettype wire

// File: tb/tb_mix_columns_seq.sv
// ============================================================================
// Module      : tb_mix_columns_seq
// Description : Directed self-checking bench for mix_columns_seq, followed by
//               a randomized streaming run checked against a nibble model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mix_columns_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_inv;
    logic        in_skip;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;

    int n_cmp;
    int n_err;

    mix_columns_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_inv    (in_inv),
        .in_skip   (in_skip),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: multiply by x, then build 4 and 9 from it
    function automatic logic [3:0] m2(input logic [3:0] x);
        return x[3] ? ({x[2:0], 1'b0} ^ 4'h3) : {x[2:0], 1'b0};
    endfunction
    function automatic logic [3:0] m4(input logic [3:0] x);
        return m2(m2(x));
    endfunction
    function automatic logic [3:0] m9(input logic [3:0] x);
        return m2(m4(x)) ^ x;
    endfunction
    function automatic logic [7:0] ref_col(input logic [7:0] c, input logic inv);
        logic [3:0] a;
        logic [3:0] b;
        a = c[7:4];
        b = c[3:0];
        if (inv) return {m9(a) ^ m2(b), m2(a) ^ m9(b)};
        return {a ^ m4(b), m4(a) ^ b};
    endfunction
    function automatic logic [15:0] ref_mix(input logic [15:0] s, input logic inv,
                                            input logic skip);
        if (skip) return s;
        return {ref_col(s[15:8], inv), ref_col(s[7:0], inv)};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Capture one block, check 3-cycle latency, leave DUT in HOLD (out_ready=0)
    task automatic capture_and_wait(input logic [15:0] d, input logic inv,
                                    input logic skip, input logic [15:0] exp,
                                    input string tag);
        @(negedge clk);
        in_data  = d;
        in_inv   = inv;
        in_skip  = skip;
        in_valid = 1'b1;
        #1;
        chk({tag, "_in_ready"}, {15'd0, in_ready}, 16'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_inv   = ~inv;
        in_skip  = ~skip;
        chk({tag, "_col0_valid"}, {15'd0, out_valid}, 16'd0);
        @(negedge clk);
        chk({tag, "_col1_valid"}, {15'd0, out_valid}, 16'd0);
        @(negedge clk);
        chk({tag, "_hold_valid"}, {15'd0, out_valid}, 16'd1);
        chk({tag, "_data"}, out_data, exp);
    endtask

    task automatic drain;
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("drain_valid", {15'd0, out_valid}, 16'd0);
    endtask

    logic [15:0] exp_q[$];
    int          sent;
    int          recv;
    logic        fired;
    logic        fire_in;
    logic        fire_out;
    logic [15:0] prev_data;
    logic        prev_stall;

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        in_inv    = 1'b0;
        in_skip   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
        chk("rst_in_ready", {15'd0, in_ready}, 16'd1);
        chk("rst_out_data", out_data, 16'h0000);

        // Directed functional vectors
        capture_and_wait(16'h1234, 1'b0, 1'b0, 16'h9608, "fwd_1234");
        drain();
        capture_and_wait(16'h9608, 1'b1, 1'b0, 16'h1234, "inv_9608");
        drain();
        capture_and_wait(16'hFFFF, 1'b0, 1'b0, 16'h6666, "fwd_ffff");
        drain();
        capture_and_wait(16'h6666, 1'b1, 1'b0, 16'hFFFF, "inv_6666");
        drain();
        capture_and_wait(16'hABCD, 1'b0, 1'b1, 16'hABCD, "skip_abcd");
        drain();
        capture_and_wait(16'h0000, 1'b0, 1'b0, 16'h0000, "fwd_zero");
        drain();

        // Backpressure: stall in HOLD, then same-cycle output + capture
        capture_and_wait(16'h1234, 1'b0, 1'b0, 16'h9608, "bp_1234");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_stall_data", out_data, 16'h9608);
            chk("bp_stall_valid", {15'd0, out_valid}, 16'd1);
            chk("bp_stall_in_ready", {15'd0, in_ready}, 16'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'hFFFF;
        in_inv    = 1'b0;
        in_skip   = 1'b0;
        #1;
        chk("bp_b2b_in_ready", {15'd0, in_ready}, 16'd1);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("bp_b2b_col0_valid", {15'd0, out_valid}, 16'd0);
        @(negedge clk);
        chk("bp_b2b_col1_valid", {15'd0, out_valid}, 16'd0);
        @(negedge clk);
        chk("bp_b2b_valid", {15'd0, out_valid}, 16'd1);
        chk("bp_b2b_data", out_data, 16'h6666);
        drain();

        // Reset during COL1 discards the block
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'h1234;
        in_inv   = 1'b0;
        in_skip  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_valid", {15'd0, out_valid}, 16'd0);
        chk("rst_mid_in_ready", {15'd0, in_ready}, 16'd1);
        chk("rst_mid_data", out_data, 16'h0000);
        @(negedge clk);
        chk("rst_mid_valid2", {15'd0, out_valid}, 16'd0);
        out_ready = 1'b0;
        capture_and_wait(16'hFFFF, 1'b0, 1'b0, 16'h6666, "post_rst");
        drain();

        // Streaming with random inputs and random backpressure
        sent       = 0;
        recv       = 0;
        fired      = 1'b0;
        prev_stall = 1'b0;
        prev_data  = 16'h0000;
        for (int cyc = 0; cyc < 600 && recv < 8; cyc++) begin
            @(negedge clk);
            if (prev_stall) begin
                chk("stream_stable_data", out_data, prev_data);
                chk("stream_stable_valid", {15'd0, out_valid}, 16'd1);
            end
            if (fired) in_valid = 1'b0;
            if (sent < 8 && !in_valid) begin
                in_valid = 1'b1;
                in_data  = 16'($urandom);
                in_inv   = 1'($urandom_range(0, 1));
                in_skip  = ($urandom_range(0, 3) == 0);
            end
            out_ready = 1'($urandom_range(0, 1));
            #1;
            fire_in  = in_valid && in_ready;
            fire_out = out_valid && out_ready;
            if (fire_out) begin
                if (exp_q.size() > 0) begin
                    chk("stream_data", out_data, exp_q.pop_front());
                end else begin
                    chk("stream_unexpected", out_data, 16'hxxxx);
                end
                recv++;
            end
            if (fire_in) begin
                exp_q.push_back(ref_mix(in_data, in_inv, in_skip));
                sent++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            fired      = fire_in;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("stream_sent", 16'(sent), 16'd8);
        chk("stream_recv", 16'(recv), 16'd8);
        chk("stream_leftover", 16'(exp_q.size()), 16'd0);
        chk("stream_idle_valid", {15'd0, out_valid}, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_mix_columns_seq

`default_nettype wire
